lsu_stage: RTL and testbench
============================

# lsu_stage

Load/store stage of the multi-cycle NPC core. It sits downstream of the execute stage and accepts one instruction bundle over the valid/ready handshake that the execute stage drives. For loads and stores it runs a single-beat request/response transaction on the data-memory port, aligns and extends load data, and hands the result bundle to the write-back stage over a second valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters. Data width is fixed at 32 and the memory port is word-addressed with byte strobes.
- clk  in  1  clock; every register samples on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid_in_exu  in  1  execute stage presents a bundle.
- ready_out_exu  out  1  stage can accept a bundle.
- func3  in  3  load/store size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_ren, mem_wen  in  1 each  load, store; never both 1.
- alu_result  in  32  effective address for memory ops, otherwise the result.
- wdata  in  32  store data, taken from the low bytes.
- gpr_wen  in  1; rd  in  5; pc  in  32  passed through unchanged.
- valid_out_wbu  out  1  result bundle valid.
- ready_in_wbu  in  1  write-back stage accepts the bundle.
- wb_data  out  32  load value or alu_result.
- gpr_wen_buf  out  1; rd_buf  out  5; pc_buf  out  32  latched pass-through fields.
- misalign_buf  out  1  the access was misaligned and no memory transaction ran.
- mem_req_valid  out  1; mem_req_ready  in  1  memory request handshake.
- mem_req_addr  out  32  word-aligned address, alu_result with bits [1:0] forced to 0.
- mem_req_wen  out  1; mem_req_wdata  out  32; mem_req_wmask  out  4  byte strobes.
- mem_resp_valid  in  1; mem_resp_rdata  in  32  response; one response per request, for stores as well as loads.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- IDLE:
  - ready_out_exu=1.
  - On valid_in_exu, latch all input fields.
  - Next state is REQ when mem_ren or mem_wen is set and the access is aligned. Otherwise the next state is DONE.
- REQ:
  - mem_req_valid=1. Request fields are driven from latched values and held stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
- RESP:
  - Wait for mem_resp_valid.
  - For a load, capture the extended data into wb_data. For a store, ignore rdata.
  - Then go to DONE.
- DONE:
  - valid_out_wbu=1 and all _buf outputs plus wb_data are stable.
  - On ready_in_wbu, go to IDLE.
  - No new bundle is accepted until IDLE (single-entry stage).
- Alignment:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - A misaligned access sets misalign_buf=1, clears gpr_wen_buf, sets wb_data=0, issues no request, and goes straight to DONE.
- Store strobes and data (off = addr[1:0]):
  - SB: wmask = 0001<<off and wdata = {4{wdata[7:0]}}.
  - SH: wmask = 0011<<off and wdata = {2{wdata[15:0]}}.
  - SW: wmask = 1111 and wdata = wdata.
- Load extraction:
  - Byte = rdata[8*off+7 : 8*off]. Halfword = rdata[8*off+15 : 8*off].
  - B and H sign-extend. BU and HU zero-extend. W takes rdata as-is.
- Non-memory bundles: wb_data = alu_result and misalign_buf=0.
- Undefined func3 on a load is treated as W.

## Timing
- Reset values: ready_out_exu=1. Every other output is 0, including all _buf fields, wb_data, and all mem_req_* signals.
- Reset is asynchronous. Asserting rst in any state forces IDLE immediately and drops mem_req_valid and valid_out_wbu in the same cycle.
- A mem_resp_valid that arrives in IDLE, REQ or DONE is ignored. A response is sampled only in RESP.
- Latency from the accept edge, cycle N:
  - Non-memory or misaligned: valid_out_wbu=1 at N+1.
  - Memory access with zero-wait memory (ready in REQ, response in the first RESP cycle): valid_out_wbu at N+3.
  - Each stall cycle on mem_req_ready or mem_resp_valid adds one cycle.
- Holding ready_in_wbu=0 keeps DONE and all outputs frozen for any number of cycles.
- Back-to-back throughput: at best one bundle every 2 cycles for non-memory and every 4 cycles for memory ops.
- A valid_in_exu asserted while not in IDLE is not accepted; the sender must hold the bundle.

## Test plan
- ALU bypass: alu_result=0x1234_5678, no mem op, ready_in_wbu=1.
  - Expect valid_out_wbu one cycle after accept, wb_data=0x1234_5678, and no mem_req_valid.
- LB sign-extension: addr=0x8000_0003, rdata=0x80AA_BBCC.
  - Expect mem_req_addr=0x8000_0000 and wb_data=0xFFFF_FF80.
  - Repeat with LBU: expect wb_data=0x0000_0080.
- SH at addr=0x8000_0002 with wdata=0xDEAD_BEEF.
  - Expect mem_req_wmask=1100, mem_req_wdata=0xBEEF_BEEF and mem_req_wen=1.
  - Expect DONE only after mem_resp_valid.
- Stalls: mem_req_ready low for 3 cycles, then mem_resp_valid low for 2 cycles.
  - Request fields stay stable throughout.
  - valid_out_wbu rises at N+8.
  - ready_in_wbu held low for 4 cycles keeps wb_data unchanged.
- Misaligned LW at 0x8000_0001: expect no mem_req_valid, misalign_buf=1, gpr_wen_buf=0, wb_data=0, and valid_out_wbu at N+1.
- Reset in RESP, then mem_resp_valid pulses in IDLE.
  - Expect all outputs at reset values and no valid_out_wbu.
  - ready_out_exu=1 immediately after reset.

Source files
------------

// File: rtl/lsu_stage.sv
// lsu_stage: single-entry load/store stage; one word-addressed memory beat per load/store,
// alignment checks, load extension and pass-through of non-memory bundles to write-back.
module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in_exu,
    output logic        ready_out_exu,
    input  logic [2:0]  func3,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] alu_result,
    input  logic [31:0] wdata,
    input  logic        gpr_wen,
    input  logic [4:0]  rd,
    input  logic [31:0] pc,
    output logic        valid_out_wbu,
    input  logic        ready_in_wbu,
    output logic [31:0] wb_data,
    output logic        gpr_wen_buf,
    output logic [4:0]  rd_buf,
    output logic [31:0] pc_buf,
    output logic        misalign_buf,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
    state_e      state_q, state_d;
    logic [2:0]  func3_q, func3_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        gpr_wen_q, gpr_wen_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        in_mis, sext, req;
    logic [1:0]  off;
    logic [31:0] shifted, ld_val;
    always_comb begin
        // func3[1:0]: 00 byte, 01 half, anything else behaves as a word
        in_mis  = (mem_ren | mem_wen) &&
                  (func3[1:0] == 2'b01 ? alu_result[0] : (func3[1:0] != 2'b00 && alu_result[1:0] != 2'b00));
        off     = addr_q[1:0];
        sext    = ~func3_q[2];
        shifted = mem_resp_rdata >> {off, 3'b000};
        ld_val  = func3_q[1:0] == 2'b00 ? {{24{sext & shifted[7]}}, shifted[7:0]} :
                  func3_q[1:0] == 2'b01 ? {{16{sext & shifted[15]}}, shifted[15:0]} : mem_resp_rdata;
        state_d    = state_q;
        func3_d    = func3_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gpr_wen_d  = gpr_wen_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            IDLE: if (valid_in_exu) begin
                func3_d    = func3;
                wen_d      = mem_wen;
                addr_d     = alu_result;
                wdata_d    = wdata;
                gpr_wen_d  = gpr_wen & ~in_mis;
                rd_d       = rd;
                pc_d       = pc;
                misalign_d = in_mis;
                wb_data_d  = in_mis ? 32'h0 : alu_result;
                state_d    = ((mem_ren | mem_wen) && !in_mis) ? REQ : DONE;
            end
            REQ:  state_d = mem_req_ready ? RESP : REQ;
            RESP: if (mem_resp_valid) begin
                wb_data_d = wen_q ? wb_data_q : ld_val;
                state_d   = DONE;
            end
            DONE: state_d = ready_in_wbu ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            func3_q    <= 3'h0;
            wen_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            gpr_wen_q  <= 1'b0;
            rd_q       <= 5'h0;
            pc_q       <= 32'h0;
            misalign_q <= 1'b0;
            wb_data_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            func3_q    <= func3_d;
            wen_q      <= wen_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gpr_wen_q  <= gpr_wen_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            wb_data_q  <= wb_data_d;
        end
    end
    // request fields are zero outside REQ so reset and idle present a quiet port
    assign req           = state_q == REQ;
    assign ready_out_exu = state_q == IDLE;
    assign valid_out_wbu = state_q == DONE;
    assign mem_req_valid = req;
    assign mem_req_addr  = req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_req_wen   = req & wen_q;
    assign mem_req_wmask = !(req && wen_q) ? 4'h0 :
                           func3_q[1:0] == 2'b00 ? 4'b0001 << off :
                           func3_q[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    assign mem_req_wdata = !(req && wen_q) ? 32'h0 :
                           func3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                           func3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign wb_data       = wb_data_q;
    assign gpr_wen_buf   = gpr_wen_q;
    assign rd_buf        = rd_q;
    assign pc_buf        = pc_q;
    assign misalign_buf  = misalign_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: table-driven plus randomized checks of lsu_stage against a byte-level model.
module tb_lsu_stage;
    logic        clk = 1'b0, rst = 1'b0;
    logic        valid_in_exu = 0, ready_out_exu;
    logic [2:0]  func3 = 0;
    logic        mem_ren = 0, mem_wen = 0, gpr_wen = 0;
    logic [31:0] alu_result = 0, wdata = 0, pc = 0;
    logic [4:0]  rd = 0;
    logic        valid_out_wbu, ready_in_wbu = 0;
    logic [31:0] wb_data, pc_buf;
    logic        gpr_wen_buf, misalign_buf;
    logic [4:0]  rd_buf;
    logic        mem_req_valid, mem_req_ready = 0, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid = 0;
    logic [31:0] mem_resp_rdata = 0;
    int checks = 0, errors = 0;

    lsu_stage dut (
        .clk(clk), .rst(rst), .valid_in_exu(valid_in_exu), .ready_out_exu(ready_out_exu),
        .func3(func3), .mem_ren(mem_ren), .mem_wen(mem_wen), .alu_result(alu_result),
        .wdata(wdata), .gpr_wen(gpr_wen), .rd(rd), .pc(pc), .valid_out_wbu(valid_out_wbu),
        .ready_in_wbu(ready_in_wbu), .wb_data(wb_data), .gpr_wen_buf(gpr_wen_buf),
        .rd_buf(rd_buf), .pc_buf(pc_buf), .misalign_buf(misalign_buf),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ren, wen; logic [2:0] f3; logic [31:0] addr, wd, rdata; int rs, ps, hold;
        logic [31:0] e_wb; logic e_mis; int e_lat; logic [3:0] e_mask; logic [31:0] e_wd;
    } vec_t;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // reference: sizes in bytes, alignment by modulo, extension by arithmetic wrap
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int size = v.f3[1:0] == 2'b00 ? 1 : v.f3[1:0] == 2'b01 ? 2 : 4;
        int off = int'(v.addr % 4);
        logic [63:0] lim = 64'd1 << (8 * size);
        logic [63:0] val = (64'(v.rdata) >> (8 * off)) % lim;
        logic mem = v.ren | v.wen;
        if (!v.f3[2] && size < 4 && val >= lim / 2) val = val - lim;
        r.e_mis  = mem && (v.addr % size != 0);
        r.e_wb   = r.e_mis ? 32'h0 : (v.ren ? val[31:0] : v.addr);
        r.e_lat  = (mem && !r.e_mis) ? 3 + v.rs + v.ps : 1;
        r.e_mask = 4'(((1 << size) - 1) << off);
        r.e_wd   = size == 1 ? v.wd[7:0] * 32'h0101_0101 : size == 2 ? v.wd[15:0] * 32'h0001_0001 : v.wd;
        return r;
    endfunction

    task automatic run(input vec_t v);
        logic g; logic [4:0] r; logic [31:0] p; logic [68:0] cap; logic saw, unstable, in_resp;
        int lat, rc, pn;
        g = 1'($urandom); r = 5'($urandom); p = $urandom;
        cap = '0; saw = 0; unstable = 0; in_resp = 0; rc = 0; pn = 0;
        chk("ready_idle", ready_out_exu, 1);
        func3 = v.f3; mem_ren = v.ren; mem_wen = v.wen; alu_result = v.addr; wdata = v.wd;
        gpr_wen = g; rd = r; pc = p; valid_in_exu = 1;
        @(posedge clk); #1;
        valid_in_exu = 0; alu_result = $urandom; wdata = $urandom; pc = $urandom; rd = 5'($urandom);
        lat = 1;
        while (!valid_out_wbu && lat < 200) begin
            mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = $urandom;
            if (mem_req_valid) begin
                if (saw && {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== cap) unstable = 1;
                cap = {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask};
                saw = 1;
                mem_req_ready = rc >= v.rs;
                mem_resp_valid = 1'($urandom);
                rc++;
            end else if (saw) begin
                mem_resp_valid = pn >= v.ps;
                if (mem_resp_valid) mem_resp_rdata = v.rdata;
                pn++;
            end
            @(posedge clk); #1;
            lat++;
        end
        mem_req_ready = 0;
        chk("latency", lat, v.e_lat);
        chk("req_seen", saw, (v.ren | v.wen) & ~v.e_mis);
        chk("req_stable", unstable, 0);
        if (saw) begin
            chk("req_addr", cap[68:37], {v.addr[31:2], 2'b00});
            chk("req_wen", cap[36], v.wen);
            if (v.wen) begin
                chk("req_wdata", cap[35:4], v.e_wd);
                chk("req_wmask", cap[3:0], v.e_mask);
            end
        end
        chk("wb_data", wb_data, v.e_wb);
        chk("misalign", misalign_buf, v.e_mis);
        chk("pass", {gpr_wen_buf, rd_buf, pc_buf}, {g & ~v.e_mis, r, p});
        chk("no_req_done", mem_req_valid, 0);
        for (int h = 0; h < v.hold; h++) begin
            mem_resp_valid = 1'($urandom); mem_resp_rdata = $urandom;
            valid_in_exu = 1; pc = $urandom;
            @(posedge clk); #1;
            chk("hold", {valid_out_wbu, ready_out_exu, wb_data, pc_buf, rd_buf}, {2'b10, v.e_wb, p, r});
        end
        valid_in_exu = 0; mem_resp_valid = 0; ready_in_wbu = 1;
        @(posedge clk); #1;
        ready_in_wbu = 0;
        chk("back_idle", {valid_out_wbu, ready_out_exu}, 2'b01);
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        // ren wen f3 addr wd rdata rs ps hold | wb mis lat mask wdata
        tbl[0]  = '{0, 0, 3'b000, 32'h1234_5678, 0, 0, 0, 0, 0, 32'h1234_5678, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 3'b000, 32'h8000_0003, 0, 32'h80AA_BBCC, 0, 0, 1, 32'hFFFF_FF80, 0, 3, 0, 0};
        tbl[2]  = '{1, 0, 3'b100, 32'h8000_0003, 0, 32'h80AA_BBCC, 0, 0, 0, 32'h0000_0080, 0, 3, 0, 0};
        tbl[3]  = '{0, 1, 3'b001, 32'h8000_0002, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'h8000_0002, 0, 4, 4'b1100, 32'hBEEF_BEEF};
        tbl[4]  = '{1, 0, 3'b010, 32'h8000_0010, 0, 32'hCAFE_F00D, 3, 2, 4, 32'hCAFE_F00D, 0, 8, 0, 0};
        tbl[5]  = '{1, 0, 3'b010, 32'h8000_0001, 0, 32'h5555_5555, 0, 0, 1, 32'h0, 1, 1, 0, 0};
        tbl[6]  = '{1, 0, 3'b001, 32'h8000_0002, 0, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001, 0, 3, 0, 0};
        tbl[7]  = '{1, 0, 3'b101, 32'h8000_0002, 0, 32'h8001_1234, 1, 0, 0, 32'h0000_8001, 0, 4, 0, 0};
        tbl[8]  = '{0, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 0, 0, 0, 0, 32'h8000_0001, 0, 3, 4'b0010, 32'hA5A5_A5A5};
        tbl[9]  = '{0, 1, 3'b010, 32'h8000_0004, 32'h1122_3344, 0, 0, 0, 0, 32'h8000_0004, 0, 3, 4'b1111, 32'h1122_3344};
        tbl[10] = '{0, 1, 3'b001, 32'h8000_0003, 32'h1, 0, 0, 0, 0, 32'h0, 1, 1, 0, 0};
        tbl[11] = '{1, 0, 3'b011, 32'h8000_0008, 0, 32'h89AB_CDEF, 0, 0, 0, 32'h89AB_CDEF, 0, 3, 0, 0};
        #12;
        chk("rst_ready", ready_out_exu, 1);
        chk("rst_outs", {valid_out_wbu, wb_data, gpr_wen_buf, rd_buf, pc_buf, misalign_buf,
                         mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        foreach (tbl[i]) run(tbl[i]);
        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 2);
            logic [2:0] f3s[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
            rv.ren = k == 1; rv.wen = k == 2; rv.f3 = f3s[$urandom_range(0, 7)];
            rv.addr = 32'h8000_0000 | 32'($urandom_range(0, 255)); rv.wd = $urandom; rv.rdata = $urandom;
            rv.rs = $urandom_range(0, 3); rv.ps = $urandom_range(0, 3); rv.hold = $urandom_range(0, 2);
            run(model(rv));
        end
        // async reset while waiting in RESP, then stray responses in IDLE
        func3 = 3'b010; mem_ren = 1; mem_wen = 0; alu_result = 32'h8000_0020; gpr_wen = 1;
        rd = 5'd5; pc = 32'h1000_0000; valid_in_exu = 1;
        @(posedge clk); #1;
        valid_in_exu = 0;
        chk("rq_before_rst", mem_req_valid, 1);
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        chk("in_resp", {mem_req_valid, valid_out_wbu, ready_out_exu, pc_buf}, {3'b000, 32'h1000_0000});
        #2 rst = 0;
        #1;
        chk("rst_async_ready", ready_out_exu, 1);
        chk("rst_async_outs", {valid_out_wbu, wb_data, gpr_wen_buf, rd_buf, pc_buf, misalign_buf,
                               mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask}, 0);
        @(negedge clk); rst = 1;
        mem_resp_valid = 1; mem_resp_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stray_resp", {valid_out_wbu, ready_out_exu, mem_req_valid, wb_data}, {3'b010, 32'h0});
        end
        mem_resp_valid = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
